// File: rtl/rock_motor_drive.sv
// Cradle-motor drive: turns latched amplitude/frequency codes into a ramped PWM rocking envelope.
// Optional ROCK_SOFTSTOP_EN: dropping enable finishes the current half-swing instead of stopping at once.
module rock_motor_drive #(
  parameter int TICK_DIV   = 48000,
  parameter int STEPS      = 16,
  parameter int DEAD_TICKS = 50,
  parameter int PWM_BITS   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [2:0]          amp,
  input  logic [2:0]          freq,
  output logic                pwm,
  output logic                dir,
  output logic                half_done,
  output logic                running,
  output logic [PWM_BITS-1:0] duty
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(STEPS);
  localparam int LW = SW + 1;
  localparam int TW = $clog2(DEAD_TICKS + 8);
  localparam int MW = SW + 1 + PWM_BITS;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, PAUSE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]       pre_cnt;
  logic [TW-1:0]       tick_cnt;
  logic [LW-1:0]       lvl;
  logic [2:0]          al;
  logic [2:0]          fl;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [MW-1:0]       prod;
  logic [PWM_BITS-1:0] duty_next;
  logic                tick;
  logic                step;
  logic                dead_done;
  logic                go;
  logic                ramping;
  logic                hard_stop;
  logic                soft_stop;

`ifdef ROCK_SOFTSTOP_EN
  assign hard_stop = 1'b0;
  assign soft_stop = !enable;
`else
  assign hard_stop = !enable;
  assign soft_stop = 1'b0;
`endif

  assign go        = enable && (amp != 3'd0) && (freq != 3'd0);
  assign tick      = (state != IDLE) && (pre_cnt == PW'(TICK_DIV - 1));
  assign step      = tick && ramping && (tick_cnt == TW'(3'd7 - fl));
  assign dead_done = tick && (state == PAUSE) && (tick_cnt == TW'(DEAD_TICKS - 1));

  // Envelope: lvl * (Al*32) / STEPS, sized so the full-scale product never overflows.
  assign prod      = MW'(lvl) * MW'({al, 5'b00000});
  assign duty_next = PWM_BITS'(prod >> SW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (go) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (hard_stop)                              state_nxt = IDLE;
        else if (soft_stop)                         state_nxt = RAMP_DOWN;
        else if (step && lvl == LW'(STEPS - 1))     state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (hard_stop)                              state_nxt = IDLE;
        else if (step && lvl <= LW'(1))             state_nxt = PAUSE;
      end
      PAUSE: begin
        // A completed dead time wins over a same-clk enable drop: the swing is already finished.
        if (dead_done)                              state_nxt = go ? RAMP_UP : IDLE;
        else if (hard_stop)                         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running = (state != IDLE);
    ramping = (state == RAMP_UP) || (state == RAMP_DOWN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt   <= '0;
      tick_cnt  <= '0;
      lvl       <= '0;
      al        <= '0;
      fl        <= '0;
      dir       <= 1'b0;
      half_done <= 1'b0;
    end else begin
      if (state == IDLE || state_nxt == IDLE || tick) pre_cnt <= '0;
      else                                            pre_cnt <= pre_cnt + PW'(1);

      // Tick phase is kept across a soft-stop turnaround so step spacing stays uniform.
      if (state == IDLE || state_nxt == IDLE || step || dead_done) tick_cnt <= '0;
      else if (tick)                                               tick_cnt <= tick_cnt + TW'(1);

      if (state_nxt == IDLE)                               lvl <= '0;
      else if (step && state == RAMP_UP && !soft_stop)     lvl <= lvl + LW'(1);
      else if (step && state == RAMP_DOWN && lvl != '0)    lvl <= lvl - LW'(1);

      if (state_nxt == RAMP_UP && state != RAMP_UP) begin
        al <= amp;
        fl <= freq;
      end

      if (dead_done) dir <= ~dir;
      half_done <= dead_done;
    end
  end

  // Duty only changes at the PWM wrap so every period is a clean, complete pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
      duty    <= '0;
      pwm     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == '1) duty <= duty_next;
      pwm <= ramping && (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_rock_motor_drive.sv
// Directed bench for rock_motor_drive with TICK_DIV=4, STEPS=16, DEAD_TICKS=2, PWM_BITS=8.
module tb_rock_motor_drive;
  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] amp;
  logic [2:0] freq;
  logic       pwm;
  logic       dir;
  logic       half_done;
  logic       running;
  logic [7:0] duty;

  rock_motor_drive #(
    .TICK_DIV(4), .STEPS(16), .DEAD_TICKS(2), .PWM_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .amp(amp), .freq(freq),
    .pwm(pwm), .dir(dir), .half_done(half_done), .running(running), .duty(duty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int amp;
    int freq;
    int len;
    int d268;
    int hi;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc;
  int   hd_q[$];
  logic dir_q[$];
  int   samp1_cyc, samp2_cyc, samp1, samp2;
  int   win_lo, win_hi, pwm_hi;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    hd_q.delete();
    dir_q.delete();
    samp1_cyc = -1; samp2_cyc = -1; samp1 = -1; samp2 = -1;
    win_lo = 1; win_hi = 0; pwm_hi = 0;
  endtask

  // cyc counts negedges since the clk in which RAMP_UP was entered (cycle 0).
  task automatic adv_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
      if (half_done === 1'b1) begin
        hd_q.push_back(cyc);
        dir_q.push_back(dir);
      end
      if (cyc == samp1_cyc) samp1 = int'(duty);
      if (cyc == samp2_cyc) samp2 = int'(duty);
      if (cyc >= win_lo && cyc <= win_hi && pwm === 1'b1) pwm_hi++;
    end
  endtask

  // Reset, then start rocking so that the PWM counter reads c0 in RAMP_UP cycle 0.
  task automatic restart(input int c0, input logic [2:0] a, input logic [2:0] f);
    enable = 1'b0; amp = a; freq = f; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (c0 - 1) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    cyc = 0;
    clear_log();
  endtask

  function automatic int hd_at(input int i);
    return (hd_q.size() > i) ? hd_q[i] : -1;
  endfunction

  function automatic int dir_at(input int i);
    return (dir_q.size() > i) ? int'(dir_q[i]) : -1;
  endfunction

  initial begin
    vec_t tv[5];
    // Phase 244 puts a PWM wrap at cycle 267, so cycle 268 shows that clk's envelope.
    tv[0] = '{4, 4, 520, 128, 128};
    tv[1] = '{7, 4, 520, 224, 224};
    tv[2] = '{1, 4, 520,  32,  32};
    tv[3] = '{3, 1, 904,  54,  54};  // lvl 9 at cycle 267
    tv[4] = '{6, 5, 392, 120, 116};  // lvl 10; PAUSE masks cnt 116..119

    reset = 1'b0; enable = 1'b0; amp = 3'd0; freq = 3'd0;
    cyc = 0;
    clear_log();
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm, 0);
    chk("rst_dir", dir, 0);
    chk("rst_half_done", half_done, 0);
    chk("rst_running", running, 0);
    chk("rst_duty", duty, 0);

    for (int i = 0; i < 5; i++) begin
      restart(244, 3'(tv[i].amp), 3'(tv[i].freq));
      chk($sformatf("v%0d_running", i), running, 1);
      samp1_cyc = 268; win_lo = 269; win_hi = 524;
      adv_to(1100);
      chk($sformatf("v%0d_half_len", i), hd_at(0), tv[i].len);
      chk($sformatf("v%0d_dir_first", i), dir_at(0), 1);
      chk($sformatf("v%0d_half_count", i), hd_q.size(), 1100 / tv[i].len);
      chk($sformatf("v%0d_duty268", i), samp1, tv[i].d268);
      chk($sformatf("v%0d_pwm_high", i), pwm_hi, tv[i].hi);
    end

    // amp change mid-ramp only takes effect at the next half-swing
    restart(244, 3'd4, 3'd4);
    samp1_cyc = 268; samp2_cyc = 780;
    adv_to(100);
    amp = 3'd2;
    adv_to(1100);
    chk("amp_hd1", hd_at(0), 520);
    chk("amp_hd2", hd_at(1), 1040);
    chk("amp_dir1", dir_at(0), 1);
    chk("amp_dir2", dir_at(1), 0);
    chk("amp_peak1", samp1, 128);
    chk("amp_peak2", samp2, 64);

    // freq=0 at the PAUSE exit returns to IDLE
    restart(244, 3'd3, 3'd7);
    adv_to(50);
    freq = 3'd0;
    win_lo = 137; win_hi = 300;
    adv_to(300);
    chk("f0_half_count", hd_q.size(), 1);
    chk("f0_half_len", hd_at(0), 136);
    chk("f0_dir", dir, 1);
    chk("f0_running", running, 0);
    chk("f0_pwm_high", pwm_hi, 0);
    chk("f0_duty", duty, 0);

    // enable drop at lvl 8 in RAMP_UP, duty 56 loaded at cycle 127
    restart(128, 3'd4, 3'd4);
    adv_to(132);
    chk("stop_pwm_before", pwm, 1);
    enable = 1'b0;
    adv_to(133);
`ifdef ROCK_SOFTSTOP_EN
    chk("stop_running", running, 1);
`else
    chk("stop_running", running, 0);
`endif
    chk("stop_pwm_lag", pwm, 1);
    adv_to(134);
`ifdef ROCK_SOFTSTOP_EN
    chk("stop_pwm_after", pwm, 1);
`else
    chk("stop_pwm_after", pwm, 0);
`endif
    win_lo = 135; win_hi = 800;
    adv_to(800);
`ifdef ROCK_SOFTSTOP_EN
    chk("stop_half_count", hd_q.size(), 1);
    chk("stop_half_at", hd_at(0), 264);
    chk("stop_dir", dir, 1);
    chk("stop_running_end", running, 0);
`else
    chk("stop_half_count", hd_q.size(), 0);
    chk("stop_pwm_high", pwm_hi, 0);
    chk("stop_dir", dir, 0);
    chk("stop_running_end", running, 0);
`endif

    // reset mid RAMP_DOWN of the second half-swing (dir=1)
    restart(244, 3'd4, 3'd4);
    adv_to(820);
    chk("rd_dir_before", dir, 1);
    chk("rd_pwm_before", pwm, 1);
    chk("rd_running_before", running, 1);
    chk("rd_duty_before", duty, 128);
    reset = 1'b0;
    #1;
    chk("rd_pwm_async", pwm, 0);
    chk("rd_dir_async", dir, 0);
    chk("rd_half_done_async", half_done, 0);
    chk("rd_running_async", running, 0);
    chk("rd_duty_async", duty, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc = -1;
    clear_log();
    adv_to(0);
    chk("rd_restart_running", running, 1);
    chk("rd_restart_dir", dir, 0);
    adv_to(530);
    chk("rd_restart_half", hd_at(0), 520);
    chk("rd_restart_dir_after", dir_at(0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
